// File: rtl/gptp_tx.sv
// gptp_tx: transmit-side gPTP framer; packs one or two timestamp write beats into a 432-bit frame word.
// Optional feature: define GPTP_TX_TIMEOUT_EN to abort a half-built two-timestamp frame after TIMEOUT_CYCLES.
module gptp_tx #(
  parameter logic [15:0] TWO_TS_MASK = 16'h000C
`ifdef GPTP_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_gptp_wr_vaild,
  output logic         tx_gptp_wr_ready,
  input  logic [3:0]   tx_gptp_wr_type,
  input  logic [79:0]  tx_gptp_wr_data,
  input  logic         tx_gptp_wr_seq_sel,
  input  logic [15:0]  tx_gptp_wr_seq,
  output logic [431:0] gptp_tx_data,
  output logic         gptp_tx_vaild,
  input  logic         gptp_tx_ready,
  output logic         tx_gptp_sent,
  output logic         tx_gptp_err
);

  typedef enum logic [1:0] {IDLE, WAIT_TS2, SEND} state_t;

  state_t         state_q;
  logic           wr_ready_q;
  logic           vaild_q;
  logic           sent_q;
  logic           err_q;
  logic           seq_int_q;
  logic [431:0]   data_q;
  logic [15:0]    cnt_q [16];

  logic           accept_d;
  logic           first_beat_d;
  logic [15:0]    seq_d;

`ifdef GPTP_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  // A beat of a different type while waiting for the second timestamp restarts framing with that beat.
  assign accept_d     = tx_gptp_wr_vaild & wr_ready_q;
  assign first_beat_d = accept_d & ((state_q == IDLE) | (tx_gptp_wr_type != data_q[83:80]));
  assign seq_d        = tx_gptp_wr_seq_sel ? tx_gptp_wr_seq : cnt_q[tx_gptp_wr_type];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ready_q <= 1'b0;
      vaild_q    <= 1'b0;
      sent_q     <= 1'b0;
      err_q      <= 1'b0;
      seq_int_q  <= 1'b0;
      data_q     <= '0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
`ifdef GPTP_TX_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      sent_q <= 1'b0;
      err_q  <= 1'b0;
      if (first_beat_d) begin
        data_q    <= {80'd0, 252'd0, seq_d, tx_gptp_wr_type, tx_gptp_wr_data};
        seq_int_q <= ~tx_gptp_wr_seq_sel;
        err_q     <= (state_q == WAIT_TS2);
`ifdef GPTP_TX_TIMEOUT_EN
        tmo_q     <= '0;
`endif
        if (TWO_TS_MASK[tx_gptp_wr_type]) begin
          state_q    <= WAIT_TS2;
          wr_ready_q <= 1'b1;
        end else begin
          state_q    <= SEND;
          wr_ready_q <= 1'b0;
          vaild_q    <= 1'b1;
        end
      end else if (accept_d) begin
        data_q[431:352] <= tx_gptp_wr_data;
        state_q         <= SEND;
        wr_ready_q      <= 1'b0;
        vaild_q         <= 1'b1;
      end else if (state_q == SEND) begin
        if (gptp_tx_ready) begin
          vaild_q    <= 1'b0;
          sent_q     <= 1'b1;
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
          // Only internally sourced sequenceIds advance the per-type counter.
          if (seq_int_q) cnt_q[data_q[83:80]] <= cnt_q[data_q[83:80]] + 16'd1;
        end
      end else if (state_q == IDLE) begin
        wr_ready_q <= 1'b1;
`ifdef GPTP_TX_TIMEOUT_EN
      end else if (state_q == WAIT_TS2) begin
        if (int'(tmo_q) >= TIMEOUT_CYCLES - 1) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
`endif
      end
    end
  end

  assign tx_gptp_wr_ready = wr_ready_q;
  assign gptp_tx_data     = data_q;
  assign gptp_tx_vaild    = vaild_q;
  assign tx_gptp_sent     = sent_q;
  assign tx_gptp_err      = err_q;

endmodule

// File: tb/tb_gptp_tx.sv
// tb_gptp_tx: vector table, directed corner sequences and randomized traffic checked against a
// transaction-level frame model for gptp_tx.
module tb_gptp_tx;
  localparam logic [15:0] twoTsMask = 16'h000C;

  logic         clk;
  logic         reset;
  logic         wrValid;
  logic         wrReady;
  logic [3:0]   wrType;
  logic [79:0]  wrData;
  logic         wrSeqSel;
  logic [15:0]  wrSeq;
  logic [431:0] txData;
  logic         txValid;
  logic         txReady;
  logic         sent;
  logic         err;

  gptp_tx #(
    .TWO_TS_MASK(16'h000C)
`ifdef GPTP_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_gptp_wr_vaild(wrValid),
    .tx_gptp_wr_ready(wrReady),
    .tx_gptp_wr_type(wrType),
    .tx_gptp_wr_data(wrData),
    .tx_gptp_wr_seq_sel(wrSeqSel),
    .tx_gptp_wr_seq(wrSeq),
    .gptp_tx_data(txData),
    .gptp_tx_vaild(txValid),
    .gptp_tx_ready(txReady),
    .tx_gptp_sent(sent),
    .tx_gptp_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [431:0] frame;
    logic         internal;
    logic [3:0]   typ;
  } expFrame_t;

  typedef struct {
    logic [3:0]  typ;
    logic [79:0] data;
    logic        sel;
    logic [15:0] seq;
    logic [15:0] expSeq;
  } vec_t;

  expFrame_t   expQ[$];
  logic [15:0] modelCnt [16];
  logic        pendValid;
  logic [3:0]  pendType;
  logic [79:0] pendTsA;
  logic [15:0] pendSeq;
  logic        pendInt;
  int          checks = 0;
  int          fails = 0;
  int          errObs = 0;
  int          errExp = 0;
  int          sentObs = 0;
  int          framesExp = 0;
  bit          monOn = 1'b0;
  bit          randReady = 1'b0;
  vec_t        vecs [8];

  task automatic checkOutput(input string name, input logic [431:0] act, input logic [431:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void clearModel();
    expQ.delete();
    for (int i = 0; i < 16; i++) modelCnt[i] = 16'h0000;
    pendValid = 1'b0;
    errObs = 0;
    errExp = 0;
    sentObs = 0;
    framesExp = 0;
  endfunction

  // Frame-level model: each accepted beat either completes a frame, opens a pending one, or replaces it.
  function automatic void modelBeat(input logic [3:0] t, input logic [79:0] d, input logic s,
                                    input logic [15:0] q);
    expFrame_t   e;
    logic [15:0] seqUse;
    if (pendValid) begin
      pendValid = 1'b0;
      if (t == pendType) begin
        e.frame = {d, 252'd0, pendSeq, t, pendTsA};
        e.internal = pendInt;
        e.typ = t;
        expQ.push_back(e);
        framesExp++;
        return;
      end
      errExp++;
    end
    seqUse = s ? q : modelCnt[t];
    if (twoTsMask[t]) begin
      pendValid = 1'b1;
      pendType = t;
      pendTsA = d;
      pendSeq = seqUse;
      pendInt = ~s;
    end else begin
      e.frame = {80'd0, 252'd0, seqUse, t, d};
      e.internal = ~s;
      e.typ = t;
      expQ.push_back(e);
      framesExp++;
    end
  endfunction

  task automatic applyStimulus(input logic [3:0] t, input logic [79:0] d, input logic s,
                               input logic [15:0] q);
    int waitCycles = 0;
    wrValid = 1'b1;
    wrType = t;
    wrData = d;
    wrSeqSel = s;
    wrSeq = q;
    while (!wrReady && waitCycles < 200) begin
      if (randReady) txReady = ($urandom_range(0, 3) != 0);
      step();
      waitCycles++;
    end
    if (!wrReady) begin
      checkOutput("wrReadyTimeout", {431'd0, wrReady}, 432'd1);
      wrValid = 1'b0;
      return;
    end
    step();
    wrValid = 1'b0;
    modelBeat(t, d, s, q);
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    checkOutput("resetVaild", {431'd0, txValid}, 432'd0);
    checkOutput("resetData", txData, 432'd0);
    checkOutput("resetWrReady", {431'd0, wrReady}, 432'd0);
    checkOutput("resetPulses", {430'd0, sent, err}, 432'd0);
    step();
    clearModel();
    reset = 1'b0;
    step();
    checkOutput("postResetWrReady", {431'd0, wrReady}, 432'd1);
  endtask

  // Predicts each handshake from the levels just before the active edge and scores the frame.
  always @(negedge clk) begin
    expFrame_t e;
    if (!reset && monOn) begin
      if (sent) sentObs++;
      if (err) errObs++;
      if (txValid && txReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedFrame", {431'd0, txValid}, 432'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("modelFrame", txData, e.frame);
          if (e.internal) modelCnt[e.typ] = modelCnt[e.typ] + 16'd1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [431:0] expected;
    logic [95:0]  rnd;
    logic [3:0]   t;
    logic [79:0]  d;

    vecs[0] = '{4'h0, 80'h123456789abc00000001, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{4'h0, 80'h00000000000100000002, 1'b0, 16'h0000, 16'h0001};
    vecs[2] = '{4'h1, 80'hfedcba98765400000003, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{4'h5, 80'h0a0b0c0d0e0f00000004, 1'b1, 16'h1234, 16'h1234};
    vecs[4] = '{4'h5, 80'h11112222333344445555, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{4'h0, 80'h99998888777766665555, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[6] = '{4'h0, 80'h00000000000000000007, 1'b0, 16'h0000, 16'h0002};
    vecs[7] = '{4'hF, 80'hffffffffffffffffffff, 1'b0, 16'h0000, 16'h0000};

    wrValid = 1'b0;
    wrType = 4'h0;
    wrData = 80'd0;
    wrSeqSel = 1'b0;
    wrSeq = 16'h0000;
    txReady = 1'b1;
    reset = 1'b0;
    step();
    doReset();
    monOn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].typ, vecs[i].data, vecs[i].sel, vecs[i].seq);
      expected = {80'd0, 252'd0, vecs[i].expSeq, vecs[i].typ, vecs[i].data};
      checkOutput($sformatf("vec%0d vaild", i), {431'd0, txValid}, 432'd1);
      checkOutput($sformatf("vec%0d data", i), txData, expected);
      checkOutput($sformatf("vec%0d wrReady", i), {431'd0, wrReady}, 432'd0);
      step();
      checkOutput($sformatf("vec%0d sent", i), {431'd0, sent}, 432'd1);
      checkOutput($sformatf("vec%0d vaildLow", i), {431'd0, txValid}, 432'd0);
    end

    // Two-timestamp frame only appears after the second beat.
    doReset();
    applyStimulus(4'h2, 80'h1, 1'b0, 16'h0);
    checkOutput("ts2NoEarlyFrame", {431'd0, txValid}, 432'd0);
    checkOutput("ts2WrReady", {431'd0, wrReady}, 432'd1);
    applyStimulus(4'h2, 80'h2, 1'b0, 16'h0);
    checkOutput("ts2Frame", txData, {80'h2, 252'd0, 16'h0000, 4'h2, 80'h1});
    step();

    // Explicit sequenceId with downstream stall: frame held, writes blocked, counter untouched.
    doReset();
    txReady = 1'b0;
    applyStimulus(4'h3, 80'h3, 1'b1, 16'hBEEF);
    applyStimulus(4'h3, 80'h4, 1'b1, 16'hBEEF);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d vaild", k), {431'd0, txValid}, 432'd1);
      checkOutput($sformatf("stall%0d data", k), txData, {80'h4, 252'd0, 16'hBEEF, 4'h3, 80'h3});
      checkOutput($sformatf("stall%0d wrReady", k), {431'd0, wrReady}, 432'd0);
      step();
    end
    txReady = 1'b1;
    step();
    checkOutput("stallSent", {431'd0, sent}, 432'd1);
    applyStimulus(4'h3, 80'h5, 1'b0, 16'h0);
    applyStimulus(4'h3, 80'h6, 1'b0, 16'h0);
    checkOutput("cnt3Unchanged", {416'd0, txData[99:84]}, 432'd0);
    step();

    // Type mismatch while waiting for the second timestamp.
    doReset();
    applyStimulus(4'h2, 80'hAAAA, 1'b0, 16'h0);
    applyStimulus(4'h0, 80'hBBBB, 1'b0, 16'h0);
    checkOutput("mismatchErr", {431'd0, err}, 432'd1);
    checkOutput("mismatchVaild", {431'd0, txValid}, 432'd1);
    checkOutput("mismatchFrame", txData, {80'd0, 252'd0, 16'h0000, 4'h0, 80'hBBBB});
    step();
    checkOutput("mismatchErrPulse", {431'd0, err}, 432'd0);
    checkOutput("mismatchSent", {431'd0, sent}, 432'd1);

    // Sequence counter wrap, preloaded to avoid 65535 real sends.
    doReset();
    dut.cnt_q[0] = 16'hFFFF;
    modelCnt[0] = 16'hFFFF;
    applyStimulus(4'h0, 80'h10, 1'b0, 16'h0);
    checkOutput("wrapSeqFFFF", {416'd0, txData[99:84]}, {416'd0, 16'hFFFF});
    step();
    applyStimulus(4'h0, 80'h11, 1'b0, 16'h0);
    checkOutput("wrapSeq0000", {416'd0, txData[99:84]}, 432'd0);
    step();

    // Reset while a frame is being offered.
    doReset();
    txReady = 1'b0;
    applyStimulus(4'h0, 80'h20, 1'b0, 16'h0);
    checkOutput("preResetVaild", {431'd0, txValid}, 432'd1);
    reset = 1'b1;
    step();
    checkOutput("midResetVaild", {431'd0, txValid}, 432'd0);
    checkOutput("midResetData", txData, 432'd0);
    clearModel();
    reset = 1'b0;
    txReady = 1'b1;
    step();
    checkOutput("midResetWrReady", {431'd0, wrReady}, 432'd1);

`ifdef GPTP_TX_TIMEOUT_EN
    applyStimulus(4'h3, 80'h30, 1'b0, 16'h0);
    for (int k = 1; k < 16; k++) begin
      step();
      checkOutput($sformatf("tmoWait%0d err", k), {431'd0, err}, 432'd0);
    end
    step();
    checkOutput("tmoErr", {431'd0, err}, 432'd1);
    checkOutput("tmoNoFrame", {431'd0, txValid}, 432'd0);
    step();
`endif

    // Randomized traffic against the frame model.
    doReset();
    randReady = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: t = 4'h0;
        1: t = 4'h2;
        2: t = 4'h3;
        default: t = 4'($urandom_range(0, 15));
      endcase
      rnd = {$urandom(), $urandom(), $urandom()};
      d = rnd[79:0];
      applyStimulus(t, d, 1'($urandom_range(0, 1)), 16'($urandom()));
    end
    randReady = 1'b0;
    txReady = 1'b1;
    for (int k = 0; k < 20 && txValid; k++) step();
    step();
    checkOutput("randQueueEmpty", 432'(expQ.size()), 432'd0);
    checkOutput("randSentCount", 432'(sentObs), 432'(framesExp));
    checkOutput("randErrCount", 432'(errObs), 432'(errExp));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
